dcache_frame_packer: RTL
========================

# dcache_frame_packer

Frame assembler that sits directly downstream of the Dcache2Frame prefetch FIFO. It pops payload words through the FIFO's `rd_vld`/`rd_en` interface. Each group of `FRAME_LEN` words is wrapped into a frame: one header word carrying a sync pattern and a sequence number, the payload, and one trailing checksum word. Frames leave on a registered valid/ready stream with start/end-of-frame markers toward the frame-output logic.

## Interface
- `DATA_WIDTH`, 32: width of the FIFO data and the frame word. Legal range 24–64.
- `FRAME_LEN`, 256: payload words per frame. Legal range 1–65536.
- `SYNC_PATTERN`, 16'hA5A5: width `DATA_WIDTH-16`. Occupies the upper bits of the header word.
- `clk` in 1: single clock, shared with the FIFO read side.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: permits a new frame to start. Sampled only in IDLE.
- `fifo_data` in DATA_WIDTH: FIFO `rd_data`.
- `fifo_vld` in 1: FIFO `rd_vld`.
- `fifo_rd_en` out 1: FIFO `rd_en`. A word is popped when `fifo_vld & fifo_rd_en`.
- `frm_data` out DATA_WIDTH: frame word.
- `frm_vld` out 1: frame word valid.
- `frm_rdy` in 1: downstream accept.
- `frm_sof` out 1: marks the header beat.
- `frm_eof` out 1: marks the checksum beat.
- `busy` out 1: high whenever state ≠ IDLE.
- `seq_num` out 16: sequence number of the next or current frame.

## Operation
- **Output register.** `frm_data`, `frm_vld`, `frm_sof` and `frm_eof` are registered. The load condition is `ld = ~frm_vld | frm_rdy`.
  - A beat is held stable while `frm_vld & ~frm_rdy`.
  - If `ld` is true and no new beat is produced, `frm_vld` is cleared to 0.
- **Combinational pop.** `fifo_rd_en = (state==BODY) & ld`. It is never asserted outside BODY.
- **IDLE**
  - Transition: if `enable & fifo_vld & ld`, load the header beat and go to HEAD_DONE→BODY. This takes effect as a direct transition to BODY in the same edge.
  - Header beat: `{SYNC_PATTERN, seq_num}`, `sof=1`, `eof=0`.
  - On entry, clear `cnt=0` and `csum=0`.
  - The header does not pop the FIFO.
- **BODY**
  - On pop: load `fifo_data` with `sof=0`, `eof=0`; `csum <= csum + fifo_data` (mod 2^DATA_WIDTH); `cnt <= cnt+1`.
  - On a pop while `cnt==FRAME_LEN-1`, go to TAIL.
  - If `ld & ~fifo_vld`, emit a bubble (`frm_vld=0`) and stay in BODY.
- **TAIL**
  - When `ld`: load `csum` (which includes the final payload word), `eof=1`.
  - Increment `seq_num`, wrapping 16'hFFFF→0.
  - Go to IDLE.
- **`enable` deassert mid-frame.** The frame completes normally. No new frame starts until `enable` returns high.
- **Counter width.** `cnt` is `clog2(FRAME_LEN+1)` bits. When `FRAME_LEN=1`, BODY lasts exactly one pop.
- **Reset mid-frame.**
  - The partial frame is abandoned: no eof is emitted, and words already popped are lost.
  - `seq_num` returns to 0.

## Timing
- **Reset values:**
  - `frm_vld=0`, `frm_sof=0`, `frm_eof=0`, `frm_data=0`
  - `fifo_rd_en=0` (state IDLE), `busy=0`
  - `seq_num=0`, `cnt=0`, `csum=0`
- **Header latency.** The header appears on `frm_*` one cycle after the IDLE cycle in which `enable & fifo_vld & ld`.
- **Payload latency.** Each payload word appears one cycle after its pop cycle.
- **Throughput.** With `frm_rdy` held high and the FIFO never empty, a frame is exactly `FRAME_LEN+2` consecutive valid beats.
  - The next header follows the checksum beat with no gap: IDLE loads the header in the cycle immediately after TAIL.
- **`fifo_rd_en` path.** `fifo_rd_en` depends combinationally on `frm_rdy`. Downstream must not make `frm_rdy` depend combinationally on `frm_vld`.
- **Simultaneous `frm_rdy` and new data.** A beat is accepted and a new beat is loaded in the same edge.
- **Marker exclusivity.** `sof` and `eof` are never both 1, including when `FRAME_LEN=1`.

## Test plan
- **Basic frame.** `DATA_WIDTH=32`, `FRAME_LEN=4`, `enable=1`, `frm_rdy=1`, FIFO supplies 1,2,3,4 → six consecutive beats:
  - 0xA5A50000 with sof
  - 1, 2, 3, 4
  - 0x0000000A with eof
  - Afterwards `seq_num=1`.
- **Checksum wrap.** Payload 0xFFFFFFFF ×4 → checksum beat 0xFFFFFFFC.
- **Backpressure and starvation.**
  - Hold `frm_rdy=0` for 3 cycles during the 2nd payload beat → `frm_data` stays stable, and `fifo_rd_en=0` throughout.
  - Drop `fifo_vld` for 2 cycles → exactly 2 bubble cycles, and the frame content is unchanged.
- **Sequence wrap and back-to-back.**
  - Preload 65535 frames (or force `seq_num`=16'hFFFF) → header low 16 bits = 0xFFFF, and the next frame's header = 0x0000.
  - Checksum beat and next header are on consecutive cycles.
- **Enable and reset.**
  - Deassert `enable` after the header → the frame completes with eof, and IDLE then waits.
  - Assert `rst` for 1 cycle after the 2nd payload pop → next cycle `frm_vld=0`, `busy=0`, `seq_num=0`; the next frame starts with header 0xA5A50000.
- **`FRAME_LEN=1`.** Payload 7 → beats 0xA5A50000 (sof), 7, 0x00000007 (eof).

Source files
------------

// File: rtl/dcache_frame_packer.sv
// Frame assembler behind the Dcache2Frame prefetch FIFO: each FRAME_LEN-word
// group is wrapped with a sync/sequence header and a trailing checksum word.
module dcache_frame_packer #(
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter int unsigned            FRAME_LEN    = 256,
    parameter logic [DATA_WIDTH-17:0] SYNC_PATTERN = 16'hA5A5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_vld,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] frm_data,
    output logic                  frm_vld,
    input  logic                  frm_rdy,
    output logic                  frm_sof,
    output logic                  frm_eof,
    output logic                  busy,
    output logic [15:0]           seq_num
);

    localparam int unsigned    CW       = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [DATA_WIDTH-1:0] csum, csum_nx;
    logic [DATA_WIDTH-1:0] data_nx;
    logic                  vld_nx, sof_nx, eof_nx;
    logic [15:0]           seq_nx;
    logic                  ld, pop;

    // The output register can take a new beat when empty or being drained.
    assign ld         = ~frm_vld | frm_rdy;
    assign fifo_rd_en = (state == BODY) & ld;
    assign pop        = fifo_rd_en & fifo_vld;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        csum_nx  = csum;
        seq_nx   = seq_num;
        data_nx  = frm_data;
        vld_nx   = frm_vld;
        sof_nx   = frm_sof;
        eof_nx   = frm_eof;
        if (ld) begin
            vld_nx = 1'b0;
            sof_nx = 1'b0;
            eof_nx = 1'b0;
        end
        unique case (state)
            IDLE: begin
                // Header load and entry into the payload phase share one edge.
                if (enable & fifo_vld & ld) begin
                    data_nx  = {SYNC_PATTERN, seq_num};
                    vld_nx   = 1'b1;
                    sof_nx   = 1'b1;
                    cnt_nx   = '0;
                    csum_nx  = '0;
                    state_nx = BODY;
                end
            end
            BODY: begin
                if (pop) begin
                    data_nx = fifo_data;
                    vld_nx  = 1'b1;
                    csum_nx = csum + fifo_data;
                    cnt_nx  = cnt + 1'b1;
                    if (cnt == LAST_CNT) state_nx = TAIL;
                end
            end
            TAIL: begin
                if (ld) begin
                    data_nx  = csum;
                    vld_nx   = 1'b1;
                    eof_nx   = 1'b1;
                    seq_nx   = seq_num + 16'd1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            csum     <= '0;
            seq_num  <= '0;
            frm_data <= '0;
            frm_vld  <= 1'b0;
            frm_sof  <= 1'b0;
            frm_eof  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            csum     <= csum_nx;
            seq_num  <= seq_nx;
            frm_data <= data_nx;
            frm_vld  <= vld_nx;
            frm_sof  <= sof_nx;
            frm_eof  <= eof_nx;
        end
    end

endmodule
